// File: rtl/arm_seq_ctrl_pkg.sv
// Shared definitions for the ARM multi-cycle sequencer: state encodings,
// instruction field positions and class codes, plus small decode helpers.
package arm_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_RS_READ = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    localparam int S_BIT = 20;
    localparam int I_BIT = 25;
    localparam int L_BIT = 20;

    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_LS  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_UND = 2'b11;

    localparam logic [3:0] RD_PC = 4'hF;

    // Register-specified shift amount: needs an extra Rs read cycle.
    function automatic logic is_reg_shift(input logic [31:0] inst);
        return !inst[I_BIT] && inst[4] && !inst[7];
    endfunction

    // TST/TEQ/CMP/CMN only update flags, never Rd.
    function automatic logic is_test_op(input logic [3:0] opcode);
        return opcode[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/arm_seq_ctrl_if.sv
// Instruction/data memory handshake bundle between the sequencer and memories.
interface arm_seq_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic ir_we;
    logic dmem_req;
    logic dmem_ack;
    logic dmem_we;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/arm_wait_timer.sv
// Bus wait counter: counts cycles a request is held; expired flags the last
// permitted wait cycle so an ack in that same cycle still wins.
module arm_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign expired = enable && (count_reg == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/arm_seq_ctrl.sv
// Multi-cycle control sequencer for the ARM core: steps fetch/decode/execute/
// memory/writeback and gates register-file and flag writes to one cycle each.
module arm_seq_ctrl
    import arm_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst,
    input  logic              cond_pass,
    arm_seq_ctrl_if.master    mem,
    output logic              rs_read,
    output logic              rd_we_en,
    output logic              cpsr_we_en,
    output logic              pc_inc,
    output logic              pc_branch,
    output logic              bus_fault,
    output logic              undef_inst,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        state
);

    state_t           state_reg;
    logic             run_reg;
    logic             bus_fault_reg;
    logic [CNT_W-1:0] retired_reg;

    logic       fetch_act;
    logic       mem_act;
    logic       iack;
    logic       dack;
    logic       is_load;
    logic [1:0] cls;
    logic       expired;
    logic       retire_now;
    logic       unused_inst;

    // run_reg keeps every strobe low for the first cycle after reset.
    assign fetch_act = run_reg && (state_reg == ST_FETCH);
    assign mem_act   = (state_reg == ST_MEM);
    assign iack      = fetch_act && mem.imem_ack;
    assign dack      = mem_act && mem.dmem_ack;
    assign is_load   = inst[L_BIT];
    assign cls       = inst[27:26];

    assign mem.imem_req = fetch_act;
    assign mem.ir_we    = iack;
    assign mem.dmem_req = mem_act;
    assign mem.dmem_we  = mem_act && !is_load;

    assign bus_fault = bus_fault_reg;
    assign retired   = retired_reg;
    assign state     = state_reg;

    assign unused_inst = ^{inst[31:28], inst[19:16], inst[11:8], inst[6:5], inst[3:0]};

    arm_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!(fetch_act || mem_act) || iack || dack),
        .enable  (fetch_act || mem_act),
        .expired (expired)
    );

    always_comb begin
        rs_read    = 1'b0;
        rd_we_en   = 1'b0;
        cpsr_we_en = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        undef_inst = 1'b0;
        retire_now = 1'b0;
        case (state_reg)
            ST_DECODE: begin
                if (!cond_pass) begin
                    pc_inc     = 1'b1;
                    retire_now = 1'b1;
                end else if (cls == CLS_BR) begin
                    pc_branch  = 1'b1;
                    retire_now = 1'b1;
                end else if (cls == CLS_UND) begin
                    undef_inst = 1'b1;
                    pc_inc     = 1'b1;
                    retire_now = 1'b1;
                end
            end
            ST_RS_READ: rs_read = 1'b1;
            ST_EXEC: begin
                rd_we_en   = !is_test_op(inst[24:21]);
                cpsr_we_en = inst[S_BIT];
                // A PC destination means the ALU result already is the next PC.
                pc_inc     = !(rd_we_en && (inst[15:12] == RD_PC));
                retire_now = 1'b1;
            end
            ST_MEM: begin
                // Stores finish on the ack cycle itself; loads continue to WB.
                pc_inc     = dack && !is_load;
                retire_now = dack && !is_load;
            end
            ST_WB: begin
                rd_we_en   = 1'b1;
                pc_inc     = (inst[15:12] != RD_PC);
                retire_now = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            run_reg       <= 1'b0;
            bus_fault_reg <= 1'b0;
            retired_reg   <= '0;
        end else begin
            run_reg <= 1'b1;
            if (retire_now) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
            case (state_reg)
                ST_FETCH: begin
                    if (iack) begin
                        state_reg <= ST_DECODE;
                    end else if (expired) begin
                        bus_fault_reg <= 1'b1;
                        state_reg     <= ST_HALT;
                    end
                end
                ST_DECODE: begin
                    if (!cond_pass) begin
                        state_reg <= ST_FETCH;
                    end else if (cls == CLS_DP) begin
                        state_reg <= is_reg_shift(inst) ? ST_RS_READ : ST_EXEC;
                    end else if (cls == CLS_LS) begin
                        state_reg <= ST_MEM;
                    end else begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_RS_READ: state_reg <= ST_EXEC;
                ST_EXEC:    state_reg <= ST_FETCH;
                ST_MEM: begin
                    if (dack) begin
                        state_reg <= is_load ? ST_WB : ST_FETCH;
                    end else if (expired) begin
                        bus_fault_reg <= 1'b1;
                        state_reg     <= ST_HALT;
                    end
                end
                ST_WB:   state_reg <= ST_FETCH;
                ST_HALT: state_reg <= ST_HALT;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// Self-checking bench for arm_seq_ctrl: per-instruction expected cycle traces
// built from the sequencing rules, directed corner cases plus random instructions.
module tb_arm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        cond_pass;
    logic        rs_read, rd_we_en, cpsr_we_en, pc_inc, pc_branch, bus_fault, undef_inst;
    logic [31:0] retired;
    logic [2:0]  state;

    arm_seq_ctrl_if bus();

    arm_seq_ctrl #(
        .TIMEOUT_CYCLES (255),
        .CNT_W          (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .cond_pass  (cond_pass),
        .mem        (bus),
        .rs_read    (rs_read),
        .rd_we_en   (rd_we_en),
        .cpsr_we_en (cpsr_we_en),
        .pc_inc     (pc_inc),
        .pc_branch  (pc_branch),
        .bus_fault  (bus_fault),
        .undef_inst (undef_inst),
        .retired    (retired),
        .state      (state)
    );

    always #5 clk = ~clk;

    localparam int B_IREQ = 9, B_IRWE = 8, B_DREQ = 7, B_DWE = 6, B_RS = 5;
    localparam int B_RDWE = 4, B_CPSR = 3, B_PCI = 2, B_PCB = 1, B_UND = 0;

    typedef struct packed {
        logic       iack;
        logic       dack;
        logic [9:0] strb;
        logic [2:0] st;
    } cyc_t;

    cyc_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retired = '0;
    logic [9:0]  obs_strb;

    assign obs_strb = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, rs_read,
                       rd_we_en, cpsr_we_en, pc_inc, pc_branch, undef_inst};

    // Expected per-cycle behaviour of one instruction, from the sequencing rules.
    task automatic build(input logic [31:0] iv, input logic cp, input int ilat, input int dlat);
        cyc_t       c;
        logic [1:0] cls;
        logic       rd_pc;
        int         op;
        exp_q.delete();
        for (int i = 1; i <= ilat; i++) begin
            c = '0; c.st = 3'd0; c.strb[B_IREQ] = 1'b1;
            if (i == ilat) begin c.strb[B_IRWE] = 1'b1; c.iack = 1'b1; end
            exp_q.push_back(c);
        end
        cls   = iv[27:26];
        rd_pc = (iv[15:12] == 4'd15);
        op    = int'(iv[24:21]);
        c = '0; c.st = 3'd1;
        if (!cp) c.strb[B_PCI] = 1'b1;
        else if (cls == 2'd2) c.strb[B_PCB] = 1'b1;
        else if (cls == 2'd3) begin c.strb[B_UND] = 1'b1; c.strb[B_PCI] = 1'b1; end
        exp_q.push_back(c);
        if (cp && cls == 2'd0) begin
            if (iv[25] == 1'b0 && iv[4] == 1'b1 && iv[7] == 1'b0) begin
                c = '0; c.st = 3'd2; c.strb[B_RS] = 1'b1; exp_q.push_back(c);
            end
            c = '0; c.st = 3'd3;
            c.strb[B_RDWE] = !(op >= 8 && op <= 11);
            c.strb[B_CPSR] = iv[20];
            c.strb[B_PCI]  = !(c.strb[B_RDWE] && rd_pc);
            exp_q.push_back(c);
        end
        if (cp && cls == 2'd1) begin
            for (int i = 1; i <= dlat; i++) begin
                c = '0; c.st = 3'd4; c.strb[B_DREQ] = 1'b1; c.strb[B_DWE] = !iv[20];
                if (i == dlat) begin c.dack = 1'b1; c.strb[B_PCI] = !iv[20]; end
                exp_q.push_back(c);
            end
            if (iv[20]) begin
                c = '0; c.st = 3'd5; c.strb[B_RDWE] = 1'b1; c.strb[B_PCI] = !rd_pc;
                exp_q.push_back(c);
            end
        end
    endtask

    // Drives one instruction cycle by cycle; max_cyc > 0 truncates the run.
    task automatic run_inst(input logic [31:0] iv, input logic cp, input int ilat,
                            input int dlat, input int max_cyc);
        cyc_t c;
        int   n;
        build(iv, cp, ilat, dlat);
        n = (max_cyc > 0 && max_cyc < exp_q.size()) ? max_cyc : exp_q.size();
        for (int k = 0; k < n; k++) begin
            c = exp_q[k];
            @(posedge clk); #1;
            bus.imem_ack = c.iack | (c.st != 3'd0 && $urandom_range(1) == 1);
            bus.dmem_ack = c.dack | (c.st != 3'd4 && $urandom_range(1) == 1);
            if (c.st == 3'd0) begin
                inst = $urandom; cond_pass = 1'($urandom_range(1));
            end else begin
                inst = iv; cond_pass = (c.st == 3'd1) ? cp : 1'($urandom_range(1));
            end
            #1;
            if (k == 0) begin
                checks++;
                if (retired !== exp_retired) begin
                    errors++;
                    $display("FAIL retired inst=%08h got=%0d exp=%0d", iv, retired, exp_retired);
                end
            end
            checks++;
            if ({obs_strb, state} !== {c.strb, c.st}) begin
                errors++;
                $display("FAIL cycle inst=%08h k=%0d strobes/state got=%b/%0d exp=%b/%0d",
                         iv, k, obs_strb, state, c.strb, c.st);
            end
            checks++;
            if (bus_fault !== 1'b0) begin
                errors++;
                $display("FAIL no_fault inst=%08h k=%0d got=%b exp=0", iv, k, bus_fault);
            end
        end
        if (n == exp_q.size()) exp_retired++;
        $display("txn inst=%08h cond=%0d ilat=%0d dlat=%0d cycles=%0d retired_exp=%0d",
                 iv, cp, ilat, dlat, n, exp_retired);
    endtask

    task automatic do_reset(input logic noisy);
        rst = 1'b1; bus.imem_ack = noisy; bus.dmem_ack = noisy;
        inst = $urandom; cond_pass = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({obs_strb, state, bus_fault, retired} !== {10'b0, 3'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset strobes=%b state=%0d fault=%b retired=%0d exp all zero",
                     obs_strb, state, bus_fault, retired);
        end
        rst = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        exp_retired = '0;
        $display("txn reset noisy=%0d", noisy);
    endtask

    task automatic check_halt();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
            #1;
            checks++;
            if ({obs_strb, state, bus_fault} !== {10'b0, 3'd6, 1'b1}) begin
                errors++;
                $display("FAIL halt i=%0d strobes=%b state=%0d fault=%b exp 0/6/1",
                         i, obs_strb, state, bus_fault);
            end
        end
        $display("txn halt checked retired=%0d", retired);
    endtask

    task automatic test_reset();
        do_reset(1'b1);
    endtask

    task automatic test_directed();
        run_inst(32'hE0821003, 1'b1, 3, 0, 0);   // ADD
        run_inst(32'hE0821413, 1'b1, 1, 0, 0);   // ADD with LSL Rs
        run_inst(32'hE3510000, 1'b1, 1, 0, 0);   // CMP
        run_inst(32'hE3510000, 1'b0, 2, 0, 0);   // CMP, condition failed
        run_inst(32'hE5910000, 1'b1, 1, 3, 0);   // LDR
        run_inst(32'hE5810000, 1'b1, 1, 2, 0);   // STR
        run_inst(32'hEA000010, 1'b1, 1, 0, 0);   // B
        run_inst(32'hEC000000, 1'b1, 1, 0, 0);   // undefined class
        run_inst(32'hE1A0F00E, 1'b1, 1, 0, 0);   // MOV pc, lr
        run_inst(32'hE591F000, 1'b1, 2, 1, 0);   // LDR pc
        run_inst(32'hE351F000, 1'b1, 1, 0, 0);   // CMP with Rd field 15
        run_inst(32'hE0821003, 1'b1, 255, 0, 0); // imem ack on last allowed cycle
        run_inst(32'hE5910000, 1'b1, 1, 255, 0); // dmem ack on last allowed cycle
    endtask

    task automatic test_random();
        logic [31:0] iv;
        for (int i = 0; i < 80; i++) begin
            iv = $urandom;
            if ($urandom_range(3) == 0) iv[15:12] = 4'hF;
            run_inst(iv, 1'($urandom_range(3) != 0), $urandom_range(1, 4), $urandom_range(1, 4), 0);
        end
    endtask

    task automatic test_rst_mid();
        run_inst(32'hE5910000, 1'b1, 1, 10, 4);
        rst = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({obs_strb, state, retired} !== {10'b0, 3'd0, 32'd0}) begin
            errors++;
            $display("FAIL rst_mid strobes=%b state=%0d retired=%0d exp all zero",
                     obs_strb, state, retired);
        end
        do_reset(1'b0);
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        run_inst(32'hE0821003, 1'b1, 300, 0, 255);
        check_halt();
        do_reset(1'b0);
        run_inst(32'hE5910000, 1'b1, 1, 300, 257);
        check_halt();
        do_reset(1'b0);
    endtask

    initial begin
        rst = 1'b1; inst = '0; cond_pass = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_rst_mid();
        run_inst(32'hE0821003, 1'b1, 1, 0, 0);
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
